// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: steps one instruction through fetch/decode/execute/memory/writeback,
// handles variable-latency memory with a timeout trap, and counts retired instructions.
module multicycle_ctrl #(
   parameter int CNT_W      = 32,
   parameter int WAIT_LIMIT = 15
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [6:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             MemReq,
   output logic             MemRW,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCEn,
   output logic             RegWrite,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ResultSrc,
   output logic             InstrDone,
   output logic [CNT_W-1:0] Instret,
   output logic             Trap,
   output logic [1:0]       TrapCause,
   output logic [3:0]       State
);

   localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXECR    = 4'd7,
      EXECI    = 4'd8,
      ALUWB    = 4'd9,
      BEQ      = 4'd10,
      JAL      = 4'd11,
      TRAP     = 4'd15
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_rw;
      logic       adr_src;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       done;
      logic       branch;
      logic       pc_upd;
      logic       trap;
   } ctl_t;

   state_t              state;
   state_t              nxt;
   ctl_t                ctl_q;
   logic [WCNT_W-1:0]   wcnt;
   logic [1:0]          cause_q;
   logic [1:0]          cause_nxt;
   logic                timeout;
   logic [CNT_W-1:0]    instret_q;

   // Moore output decode; registered from the next state so outputs change with the state.
   function automatic ctl_t decode(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.mem_req = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
         DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
         MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
         MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
         MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
         MEMWRITE: begin c.mem_req = 1'b1; c.mem_rw = 1'b1; c.adr_src = 1'b1; end
         EXECR:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
         EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
         ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
         BEQ:      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; c.done = 1'b1; end
         JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_upd = 1'b1; end
         TRAP:     c.trap = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   // A request may stall WAIT_LIMIT cycles; a further stalled cycle traps, unless MemReady arrives in it.
   assign timeout = ctl_q.mem_req && !MemReady && (wcnt == WCNT_W'(WAIT_LIMIT));

   always_comb begin
      nxt       = state;
      cause_nxt = cause_q;
      case (state)
         IDLE:     nxt = FETCH;
         FETCH:    if (MemReady) nxt = DECODE;
         DECODE: begin
            case (Opcode)
               OP_LOAD, OP_STORE: nxt = MEMADR;
               OP_RTYPE:          nxt = EXECR;
               OP_ITYPE:          nxt = EXECI;
               OP_BEQ:            nxt = BEQ;
               OP_JAL:            nxt = JAL;
               default: begin
                  nxt       = TRAP;
                  cause_nxt = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEMADR:   nxt = Opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  if (MemReady) nxt = MEMWB;
         MEMWB:    nxt = FETCH;
         MEMWRITE: if (MemReady) nxt = FETCH;
         EXECR:    nxt = ALUWB;
         EXECI:    nxt = ALUWB;
         ALUWB:    nxt = FETCH;
         BEQ:      nxt = FETCH;
         JAL:      nxt = ALUWB;
         TRAP:     nxt = TRAP;
         default:  nxt = IDLE;
      endcase
      if (timeout) begin
         nxt       = TRAP;
         cause_nxt = CAUSE_TIMEOUT;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         ctl_q     <= '0;
         wcnt      <= '0;
         cause_q   <= 2'b00;
         instret_q <= '0;
      end else begin
         state <= nxt;
         ctl_q <= decode(nxt);
         if (MemReady || (nxt != state))
            wcnt <= '0;
         else if (ctl_q.mem_req)
            wcnt <= wcnt + WCNT_W'(1);
         if ((nxt == TRAP) && (state != TRAP))
            cause_q <= cause_nxt;
         if (InstrDone)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign MemReq    = ctl_q.mem_req;
   assign MemRW     = ctl_q.mem_rw;
   assign AdrSrc    = ctl_q.adr_src;
   assign RegWrite  = ctl_q.reg_write;
   assign ALUSrcA   = ctl_q.src_a;
   assign ALUSrcB   = ctl_q.src_b;
   assign ALUOp     = ctl_q.alu_op;
   assign ResultSrc = ctl_q.result_src;
   assign Trap      = ctl_q.trap;
   assign TrapCause = cause_q;
   assign State     = state;
   assign Instret   = instret_q;

   // Handshake-dependent strobes: fetch completion and store completion act in the ready cycle.
   assign IRWrite   = (state == FETCH) && MemReady;
   assign PCEn      = ((state == FETCH) && MemReady) || ctl_q.pc_upd || (ctl_q.branch && Zero);
   assign InstrDone = ctl_q.done || ((state == MEMWRITE) && MemReady);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle state
// schedule from the opcode class and memory wait counts, then checked cycle by cycle.
module tb_multicycle_ctrl;

   localparam int CW    = 4;
   localparam int LIMIT = 15;

   logic          CLK = 1'b0;
   logic          RST;
   logic [6:0]    Opcode;
   logic          Zero;
   logic          MemReady;
   logic          MemReq, MemRW, AdrSrc, IRWrite, PCEn, RegWrite;
   logic [1:0]    ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic          InstrDone;
   logic [CW-1:0] Instret;
   logic          Trap;
   logic [1:0]    TrapCause;
   logic [3:0]    State;

   int checks   = 0;
   int failures = 0;
   int exp_instret = 0;
   int exp_cause   = 0;

   multicycle_ctrl #(.CNT_W(CW), .WAIT_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .MemReq(MemReq), .MemRW(MemRW), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCEn(PCEn),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ResultSrc(ResultSrc), .InstrDone(InstrDone), .Instret(Instret), .Trap(Trap),
      .TrapCause(TrapCause), .State(State)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output table from the state chart:
   // {MemReq,MemRW,AdrSrc,IRWrite,PCEn,RegWrite,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,InstrDone,Trap,TrapCause}
   function automatic logic [17:0] exp_out(input int st, input bit mr, input bit z);
      bit mreq = 0, mrw = 0, adr = 0, irw = 0, pce = 0, rw = 0, done = 0, trp = 0;
      bit [1:0] a = 0, b = 0, op = 0, rs = 0, tc = 0;
      case (st)
         1:  begin mreq = 1; b = 2; rs = 2; irw = mr; pce = mr; end
         2:  begin a = 1; b = 1; end
         3:  begin a = 2; b = 1; end
         4:  begin mreq = 1; adr = 1; end
         5:  begin rs = 1; rw = 1; done = 1; end
         6:  begin mreq = 1; mrw = 1; adr = 1; done = mr; end
         7:  begin a = 2; op = 2; end
         8:  begin a = 2; b = 1; op = 2; end
         9:  begin rw = 1; done = 1; end
         10: begin a = 2; op = 1; pce = z; done = 1; end
         11: begin a = 1; b = 2; pce = 1; end
         15: begin trp = 1; tc = 2'(exp_cause); end
         default: ;
      endcase
      return {mreq, mrw, adr, irw, pce, rw, a, b, op, rs, done, trp, tc};
   endfunction

   // One clock cycle: drive inputs at the falling edge, check, then advance to the next falling edge.
   task automatic step(input int st, input bit mr, input bit z, input bit rstn);
      logic [17:0] e;
      RST = rstn; MemReady = mr; Zero = z;
      #1;
      e = exp_out(st, mr, z);
      check("state", 64'(State), 64'(st));
      check("outputs", 64'({MemReq, MemRW, AdrSrc, IRWrite, PCEn, RegWrite, ALUSrcA, ALUSrcB,
                            ALUOp, ResultSrc, InstrDone, Trap, TrapCause}), 64'(e));
      check("instret", 64'(Instret), 64'(exp_instret));
      if (!rstn) begin
         exp_instret = 0;
         exp_cause   = 0;
      end else if (e[3]) begin
         exp_instret = (exp_instret + 1) % (1 << CW);
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic nstep(input int st);
      step(st, 1'($urandom), 1'($urandom), 1'b1);
   endtask

   // A memory phase stalls w cycles; more than LIMIT stalls ends in a timeout trap.
   task automatic mem_stage(input int st, input int w, output bit trapped);
      int n;
      n = (w > LIMIT) ? LIMIT + 1 : w;
      trapped = 0;
      for (int i = 0; i < n; i++) step(st, 1'b0, 1'($urandom), 1'b1);
      if (w > LIMIT) begin
         exp_cause = 2;
         trapped   = 1;
      end else begin
         step(st, 1'b1, 1'($urandom), 1'b1);
      end
   endtask

   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit z,
                            output bit trapped);
      Opcode = op;
      mem_stage(1, fw, trapped);
      if (!trapped) begin
         nstep(2);
         case (op)
            7'b0000011: begin nstep(3); mem_stage(4, mw, trapped); if (!trapped) nstep(5); end
            7'b0100011: begin nstep(3); mem_stage(6, mw, trapped); end
            7'b0110011: begin nstep(7); nstep(9); end
            7'b0010011: begin nstep(8); nstep(9); end
            7'b1100011: step(10, 1'($urandom), z, 1'b1);
            7'b1101111: begin nstep(11); nstep(9); end
            default:    begin exp_cause = 1; trapped = 1; end
         endcase
      end
   endtask

   task automatic recover(input int hold);
      for (int i = 0; i < hold; i++) nstep(15);
      step(15, 1'($urandom), 1'($urandom), 1'b0);
      nstep(0);
   endtask

   initial begin
      logic [6:0] ops [16];
      bit trapped;
      int fw, mw, r;
      ops = '{7'b0000011, 7'b0000011, 7'b0100011, 7'b0100011, 7'b0110011, 7'b0110011,
              7'b0010011, 7'b0010011, 7'b1100011, 7'b1100011, 7'b1101111, 7'b1101111,
              7'b1111111, 7'b0000000, 7'b0110011, 7'b0010011};
      RST = 1'b0; Opcode = 7'b0110011; Zero = 1'b0; MemReady = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      step(0, 1'b1, 1'b1, 1'b0);
      nstep(0);

      run_instr(7'b0110011, 0, 0, 1'b0, trapped);
      check("rtype_retired", 64'(Instret), 64'(1));
      run_instr(7'b0000011, 0, 3, 1'b0, trapped);
      run_instr(7'b1100011, 0, 0, 1'b1, trapped);
      run_instr(7'b1100011, 1, 0, 1'b0, trapped);
      run_instr(7'b0100011, 0, 0, 1'b0, trapped);
      run_instr(7'b0010011, 2, 0, 1'b0, trapped);
      run_instr(7'b1101111, 0, 0, 1'b0, trapped);

      run_instr(7'b1111111, 0, 0, 1'b0, trapped);
      check("illegal_trapped", 64'(trapped), 64'(1));
      recover(20);

      run_instr(7'b0100011, 0, LIMIT + 1, 1'b0, trapped);
      recover(3);
      run_instr(7'b0100011, 0, LIMIT, 1'b0, trapped);
      run_instr(7'b0000011, LIMIT, LIMIT, 1'b0, trapped);
      run_instr(7'b0110011, LIMIT + 1, 0, 1'b0, trapped);
      recover(2);

      Opcode = 7'b0100011;
      step(1, 1'b1, 1'b0, 1'b1);
      nstep(2);
      nstep(3);
      step(6, 1'b0, 1'b0, 1'b1);
      step(6, 1'b0, 1'b1, 1'b1);
      step(6, 1'b0, 1'b0, 1'b0);
      nstep(0);

      for (int n = 0; n < 80; n++) begin
         r  = $urandom_range(0, 15);
         fw = ($urandom_range(0, 9) == 0) ? LIMIT : $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0:       mw = LIMIT;
            1:       mw = LIMIT + 1;
            default: mw = $urandom_range(0, 3);
         endcase
         run_instr(ops[r], fw, mw, 1'($urandom), trapped);
         if (trapped) recover($urandom_range(1, 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
